// File: rtl/progmem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words of an
// instruction memory, then releases the core and serves instruction fetches.
// Latency: a byte is accepted on the edge where load_valid & load_ready are
// both high; core_en rises one edge after the load_last transfer.
// Fetch data is combinational.
// Backpressure: load_ready is low during reset, in RUN and in ERR. The loader
// never stalls mid-image.
// Ports: clk/rst (async active-high); load_valid/load_byte/load_last/load_ready
// form the byte stream; core_en/load_done/load_err report status;
// progmem_addr/progmem_data form the core fetch port.
module progmem_loader #(
  parameter int DEPTH       = 256,
  parameter int INST_W      = 32,
  parameter int INST_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  input  logic [7:0]             load_byte,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic                   core_en,
  input  logic [INST_ADDR_W-1:0] progmem_addr,
  output logic [INST_W-1:0]      progmem_data,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

  state_t            state;
  logic [AW:0]       wptr;       // one extra bit so wptr can reach DEPTH
  logic [1:0]        bidx;
  logic [31:0]       sr;         // partial word; bytes above bidx are always zero
  logic [31:0]       mem [DEPTH];
  logic [DEPTH-1:0]  wvld;       // word written since the last reset

  logic        xfer;
  logic        word_wr;
  logic        ovf;
  logic        mem_we;
  logic [31:0] wdata;

  assign xfer    = load_valid & load_ready;
  assign word_wr = xfer & ((bidx == 2'd3) | load_last);
  // wptr never exceeds DEPTH, so its top bit alone means wptr == DEPTH.
  assign ovf     = wptr[AW];
  assign mem_we  = word_wr & ~ovf;
  // sr is cleared after every word write, so OR-ing in the new byte gives the
  // zero-filled upper bytes needed for a short final word.
  assign wdata   = sr | ({24'b0, load_byte} << {bidx, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      bidx       <= '0;
      sr         <= '0;
      wvld       <= '0;
      load_ready <= 1'b0;
      core_en    <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          load_ready <= 1'b1;
          if (xfer) begin
            if (word_wr) begin
              if (ovf) begin
                state      <= ERR;
                load_err   <= 1'b1;
                load_ready <= 1'b0;
              end else begin
                wvld[wptr[AW-1:0]] <= 1'b1;
                wptr <= wptr + 1'b1;
                bidx <= '0;
                sr   <= '0;
                if (load_last) begin
                  state      <= RUN;
                  core_en    <= 1'b1;
                  load_done  <= 1'b1;
                  load_ready <= 1'b0;
                end else begin
                  state <= LOAD;
                end
              end
            end else begin
              sr    <= wdata;
              bidx  <= bidx + 1'b1;
              state <= LOAD;
            end
          end
        end
        default: ;  // RUN and ERR ignore the load stream until reset
      endcase
    end
  end

  // Array has no reset; wvld decides whether a word holds current image data.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr[AW-1:0]] <= wdata;
  end

  logic [AW-1:0] rd_idx;
  logic          in_range;
  logic [31:0]   rd_word;
  logic          addr_lsb_unused;

  assign rd_idx          = progmem_addr[AW+1:2];
  assign in_range        = ~|progmem_addr[INST_ADDR_W-1:AW+2];
  assign addr_lsb_unused = ^progmem_addr[1:0];

  always_comb begin
    rd_word = NOP;
    if (state == RUN && in_range && wvld[rd_idx]) rd_word = mem[rd_idx];
    progmem_data = INST_W'(rd_word);
  end

endmodule

// File: tb/tb_progmem_loader.sv
module tb_progmem_loader;
  localparam int DEPTH = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        core_en;
  logic [31:0] progmem_addr = 32'h0;
  logic [31:0] progmem_data;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int failures = 0;

  progmem_loader #(.DEPTH(DEPTH), .INST_W(32), .INST_ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .core_en(core_en),
    .progmem_addr(progmem_addr), .progmem_data(progmem_data),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The image is simply the list of accepted bytes; word i is bytes 4i..4i+3.
  logic [7:0] img[$];
  bit run_m = 0, err_m = 0, rdy_m = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      img.delete();
      run_m = 0; err_m = 0; rdy_m = 0;
    end else begin
      if (load_valid && rdy_m) begin
        int n;
        img.push_back(load_byte);
        n = img.size();
        if ((n % 4 == 0) || load_last) begin
          if ((n - 1) / 4 >= DEPTH) err_m = 1;
          else if (load_last) run_m = 1;
        end
      end
      rdy_m = !run_m && !err_m;
    end
  end

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    logic [31:0] w;
    int i;
    if (!run_m || a >= 4 * DEPTH) return NOP;
    i = int'(a) / 4;
    if (4 * i >= img.size()) return NOP;
    w = 32'h0;
    for (int b = 0; b < 4; b++)
      if (4 * i + b < img.size()) w[8*b +: 8] = img[4*i+b];
    return w;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    cmp("load_ready", {31'b0, load_ready}, {31'b0, rdy_m});
    cmp("core_en",    {31'b0, core_en},    {31'b0, run_m});
    cmp("load_done",  {31'b0, load_done},  {31'b0, run_m});
    cmp("load_err",   {31'b0, load_err},   {31'b0, err_m});
    cmp("progmem_data", progmem_data, exp_data(progmem_addr));
  end

  // ---------------- stimulus ----------------
  logic [7:0] stim [0:127];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit got = 0;
    load_valid = 1'b1; load_byte = b; load_last = last;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk); got = load_ready;
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL handshake actual=ready_low required=ready_high t=%0t", $time);
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps
  task automatic send_img(input int n, input int gap_mode, input bit with_last);
    for (int i = 0; i < n; i++) begin
      send_byte(stim[i], with_last && (i == n - 1));
      if (i != n - 1) begin
        int g;
        g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        for (int k = 0; k < g; k++) begin
          load_byte = 8'($urandom);
          load_last = 1'($urandom);
          tick();
        end
        load_last = 1'b0;
      end
    end
  endtask

  task automatic sweep_reads(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (k % 5 == 4) progmem_addr = $urandom | 32'h0001_0000;
      else progmem_addr = $urandom_range(0, 4 * DEPTH + 15);
      tick();
    end
  endtask

  task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
    progmem_addr = a; #1;
    cmp(nm, progmem_data, exp);
  endtask

  task automatic set_stim(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                          input logic [7:0] b6, input logic [7:0] b7);
    stim[0] = b0; stim[1] = b1; stim[2] = b2; stim[3] = b3;
    stim[4] = b4; stim[5] = b5; stim[6] = b6; stim[7] = b7;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold;
    // reset state
    tick(); tick();
    cmp("rst_ready", {31'b0, load_ready}, 32'h0);
    cmp("rst_data", progmem_data, NOP);
    rst = 1'b0;

    // 8-byte image, last on byte 8
    set_stim(8'h13, 8'h01, 8'h20, 8'h00, 8'h93, 8'h01, 8'h60, 8'hFF);
    send_img(8, 0, 1);
    cmp("run_core_en", {31'b0, core_en}, 32'h1);
    cmp("run_done", {31'b0, load_done}, 32'h1);
    peek("w0", 32'h0, 32'h0020_0113);
    peek("w1_a4", 32'h4, 32'hFF60_0193);
    peek("w1_a6", 32'h6, 32'hFF60_0193);
    sweep_reads(20);

    // 5-byte image, last = AB
    do_reset();
    set_stim(8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, 8'h0, 8'h0, 8'h0);
    send_img(5, 0, 1);
    peek("partial_w1", 32'h4, 32'h0000_00AB);
    peek("unwritten_a8", 32'h8, NOP);
    peek("far_addr", 32'h0001_0000, NOP);
    sweep_reads(10);

    // single byte with last straight from IDLE
    do_reset();
    tick();
    stim[0] = 8'h5A;
    send_img(1, 0, 1);
    cmp("idle_last_run", {31'b0, core_en}, 32'h1);
    peek("idle_last_w0", 32'h0, 32'h0000_005A);

    // 12 bytes back-to-back, then the same bytes with valid every other cycle
    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
    do_reset();
    send_img(12, 0, 1);
    sweep_reads(10);
    do_reset();
    send_img(12, 1, 1);
    peek("gap_w2", 32'h8, {stim[11], stim[10], stim[9], stim[8]});
    sweep_reads(10);

    // overflow: 68 bytes into 16 words
    do_reset();
    for (int i = 0; i < 68; i++) stim[i] = 8'($urandom);
    send_img(68, 0, 0);
    cmp("ovf_err", {31'b0, load_err}, 32'h1);
    cmp("ovf_core_en", {31'b0, core_en}, 32'h0);
    cmp("ovf_ready", {31'b0, load_ready}, 32'h0);
    load_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      load_byte = 8'($urandom); load_last = 1'($urandom);
      progmem_addr = $urandom_range(0, 4 * DEPTH - 1);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    cmp("ovf_sticky", {31'b0, load_err}, 32'h1);

    // async reset mid-load, then reload 4 bytes
    do_reset();
    for (int i = 0; i < 6; i++) stim[i] = 8'($urandom);
    send_img(6, 0, 0);
    #3 rst = 1'b1;
    #1;
    cmp("arst_ready", {31'b0, load_ready}, 32'h0);
    cmp("arst_core_en", {31'b0, core_en}, 32'h0);
    cmp("arst_err", {31'b0, load_err}, 32'h0);
    cmp("arst_data", progmem_data, NOP);
    tick();
    rst = 1'b0;
    set_stim(8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0, 8'h0, 8'h0, 8'h0);
    send_img(4, 0, 1);
    peek("reload_w0", 32'h0, 32'hDEAD_BEEF);
    peek("reload_w1", 32'h4, NOP);

    // load stream activity in RUN has no effect
    peek("run_hold_pre", 32'h0, 32'hDEAD_BEEF);
    hold = progmem_data;
    load_valid = 1'b1; load_last = 1'b1;
    for (int k = 0; k < 20; k++) begin
      load_byte = 8'($urandom);
      tick();
      cmp("run_hold_data", progmem_data, hold);
    end
    load_valid = 1'b0; load_last = 1'b0;

    // randomized images
    for (int r = 0; r < 8; r++) begin
      int n;
      bit wl;
      n = $urandom_range(1, 70);
      wl = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      do_reset();
      send_img(n, 2, wl);
      sweep_reads(15);
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/progmem_loader.md
PROGMEM_LOADER -- requirements
Module: progmem_loader

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory depth in 32-bit words (power of two, 16..4096).
REQ-002 Parameter INST_W, default 32: instruction width in bits.
REQ-003 Parameter INST_ADDR_W, default 32: fetch address width in bits.
REQ-004 Port clk  input  1: single clock; all state changes occur on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port load_valid  input  1: a loader byte is present on load_byte.
REQ-007 Port load_byte  input  8: program image byte, little-endian within each word.
REQ-008 Port load_last  input  1: qualifies the final image byte; sampled with load_valid.
REQ-009 Port load_ready  output  1: block accepts a byte this cycle.
REQ-010 Port core_en  output  1: core enable; drives the core en input.
REQ-011 Port progmem_addr  input  INST_ADDR_W: core fetch byte address.
REQ-012 Port progmem_data  output  INST_W: instruction returned to the core.
REQ-013 Port load_done  output  1: image loaded successfully; core is running.
REQ-014 Port load_err  output  1: image overflowed DEPTH; sticky until reset.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN and ERR.
REQ-016 A byte SHALL transfer only on a rising edge where load_valid=1 and load_ready=1.
REQ-017 load_ready SHALL be 1 in IDLE and LOAD, and 0 in RUN and ERR.
REQ-018 IDLE SHALL go to LOAD on the first transfer; that byte is stored as byte 0 of word 0.
REQ-019 Bytes SHALL assemble into a 32-bit shift register with byte index 0..3; the word writes to mem[wptr] on the byte-3 transfer, then wptr increments and the byte index clears.
REQ-020 On a load_last transfer with byte index not equal to 3, the partial word SHALL be written with zero-filled upper bytes in the same cycle.
REQ-021 A load_last transfer that does not overflow SHALL move to RUN the next cycle.
REQ-022 A word write with wptr = DEPTH SHALL be discarded, and the FSM SHALL enter ERR (load_err=1, core_en=0) and remain there until reset.
REQ-023 A transfer in IDLE carrying load_last SHALL write word 0 and go directly to RUN.
REQ-024 core_en SHALL be 1 only in RUN; load_done SHALL equal (state==RUN).
REQ-025 In RUN, progmem_data SHALL be combinational: mem[progmem_addr[log2(DEPTH)+1:2]], with address bits [1:0] ignored.
REQ-026 In RUN, any progmem_addr >= 4*DEPTH SHALL return NOP 0x00000013.
REQ-027 In IDLE, LOAD and ERR, progmem_data SHALL be 0x00000013.
REQ-028 Words not written in the current load SHALL read 0x00000013; the array is NOP-filled at reset, or a per-word valid bit is kept.
REQ-029 load_valid=0 mid-word SHALL hold the byte index and shift-register contents indefinitely.
REQ-030 Load transfers SHALL have no effect in RUN or ERR.

Reset
REQ-031 Asserting rst SHALL immediately force state=IDLE, wptr=0, byte index=0, core_en=0, load_done=0, load_err=0, load_ready=0, and progmem_data=0x00000013.
REQ-032 load_ready SHALL become 1 on the first clk edge after rst deasserts.
REQ-033 rst asserted mid-LOAD SHALL abandon the partial image; a subsequent load SHALL restart at word 0, and all words read NOP until rewritten.

Verification
REQ-034 Load 8 bytes 13 01 20 00 93 01 60 FF with load_last on the 8th -> mem[0]=0x00200113, mem[1]=0xFF600193; next cycle core_en=1, load_done=1; progmem_addr=4 returns 0xFF600193; progmem_addr=6 returns the same.
REQ-035 Load 5 bytes, last = AB -> mem[1]=0x000000AB; progmem_addr=8 returns 0x00000013; progmem_addr=0x10000 returns 0x00000013.
REQ-036 With DEPTH=16, load 68 bytes -> word 16 is not written, load_err=1, core_en=0, load_ready=0; state is held through 100 further cycles of load_valid.
REQ-037 Toggle load_valid every other cycle across a 12-byte load -> image is identical to the back-to-back load; core_en stays 0 until 1 cycle after load_last.
REQ-038 Assert rst asynchronously between clk edges after 6 bytes -> outputs reset immediately; reloading 4 bytes with last gives mem[0]=new word and mem[1] reads NOP.
REQ-039 In RUN, drive load_valid=1 with load_last for 20 cycles -> memory unchanged, load_ready=0, progmem_data stable.
